// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, presents it to instruction memory and buffers {pc, instr} pairs for decode.
// Build macro FETCH_PERF_CNT_EN enables the saturating accepted-fetch counter on fetch_count.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}},
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_instr,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  halted,
    output logic [31:0]           fetch_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc_mem_r    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         head_r;
    logic [AW-1:0]         tail_r;
    logic [CW-1:0]         count_r;
    logic                  halted_r;

    logic out_valid_s;
    logic pop_s;
    logic push_ok_s;
    logic zero_word_s;
    logic push_s;
    logic halt_s;

    // Handshake, push gating and head-entry output selection
    always_comb begin
        out_valid_s = (count_r != {CW{1'b0}});
        pop_s       = out_valid_s & out_ready;
        // A pop in the same edge frees a slot, so a full FIFO can still accept
        push_ok_s   = ~halted_r & ((count_r < DEPTH_C) | pop_s);
        zero_word_s = (mem_instr[31:0] == 32'h0000_0000);
        push_s      = ~redirect_valid & push_ok_s & ~zero_word_s;
        halt_s      = ~redirect_valid & push_ok_s & zero_word_s;
        if (out_valid_s) begin
            out_pc    = pc_mem_r[head_r];
            out_instr = instr_mem_r[head_r];
        end else begin
            out_pc    = {DATA_WIDTH{1'b0}};
            out_instr = {DATA_WIDTH{1'b0}};
        end
    end

    assign out_valid = out_valid_s;
    assign mem_addr  = pc_r;
    assign halted    = halted_r;

    // PC, FIFO pointers, occupancy and halt state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            head_r   <= {AW{1'b0}};
            tail_r   <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r     <= redirect_pc;
            head_r   <= {AW{1'b0}};
            tail_r   <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            halted_r <= 1'b0;
        end else begin
            if (push_s) begin
                pc_r   <= pc_r + DATA_WIDTH'(3'd4);
                tail_r <= tail_r + AW'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + AW'(1'b1);
            end
            if (halt_s) begin
                halted_r <= 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale contents are masked by the pointers after reset or flush
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]    <= pc_r;
            instr_mem_r[tail_r] <= mem_instr;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;

    // Saturating push counter; only reset clears it, redirects do not
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_r <= 32'h0000_0000;
        end else if (push_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
            fetch_count_r <= fetch_count_r + 32'h0000_0001;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model of the fetch stage.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] mem_addr;
    logic [63:0] mem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_instr;
    logic        halted;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory image: mode 0 returns 0x33 everywhere, mode 1 an address-derived word;
    // zero_addr returns a word whose low half is zero (upper half deliberately non-zero).
    int          mem_mode  = 0;
    logic [63:0] zero_addr = 64'h3;

    // Reference model state
    logic [63:0] m_pc;
    logic        m_halted;
    logic [31:0] m_fc;
    logic [63:0] q_pc[$];
    logic [63:0] q_instr[$];

    instruction_fetch_unit #(
        .DATA_WIDTH(64),
        .RESET_PC  (64'h0),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_instr     (mem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [63:0] addr, input int mode,
                                             input logic [63:0] za);
        if (addr == za) return {32'hDEAD_BEEF, 32'h0000_0000};
        if (mode == 0) return 64'h33;
        return {~addr[31:0], addr[31:0] | 32'h1};
    endfunction

    assign mem_instr = mem_word(mem_addr, mem_mode, zero_addr);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs presented to the DUT.
    task automatic model_edge();
        logic        pop;
        logic        push_ok;
        logic [63:0] w;
        if (rst) begin
            m_pc = 64'h0; m_halted = 1'b0; m_fc = 32'h0;
            q_pc.delete(); q_instr.delete();
        end else begin
            pop     = (q_pc.size() > 0) && out_ready;
            push_ok = !m_halted && ((q_pc.size() < 4) || pop);
            if (redirect_valid) begin
                q_pc.delete(); q_instr.delete();
                m_pc = redirect_pc; m_halted = 1'b0;
            end else begin
                if (pop) begin
                    void'(q_pc.pop_front());
                    void'(q_instr.pop_front());
                end
                if (push_ok) begin
                    w = mem_word(m_pc, mem_mode, zero_addr);
                    if (w[31:0] == 32'h0) begin
                        m_halted = 1'b1;
                    end else begin
                        q_pc.push_back(m_pc);
                        q_instr.push_back(w);
                        m_pc = m_pc + 64'd4;
                        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_fc;
`ifdef FETCH_PERF_CNT_EN
        exp_fc = m_fc;
`else
        exp_fc = 32'h0;
`endif
        check_eq("out_valid", {63'h0, out_valid}, {63'h0, q_pc.size() > 0});
        check_eq("out_pc", out_pc, (q_pc.size() > 0) ? q_pc[0] : 64'h0);
        check_eq("out_instr", out_instr, (q_instr.size() > 0) ? q_instr[0] : 64'h0);
        check_eq("mem_addr", mem_addr, m_pc);
        check_eq("halted", {63'h0, halted}, {63'h0, m_halted});
        check_eq("fetch_count", {32'h0, fetch_count}, {32'h0, exp_fc});
    endtask

    task automatic step(input logic r, input logic rv, input logic [63:0] rp, input logic rdy);
        rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
        m_pc = 64'h0; m_halted = 1'b0; m_fc = 32'h0;

        // Free run with 0x33 everywhere
        step(1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        check_eq("rst_valid", {63'h0, out_valid}, 64'h0);
        check_eq("rst_addr", mem_addr, 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("first_valid", {63'h0, out_valid}, 64'h1);
        check_eq("first_instr", out_instr, 64'h33);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

        // Backpressure, then drain
        mem_mode = 1;
        step(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
        check_eq("bp_addr_hold", mem_addr, 64'h10);
        check_eq("bp_head", out_pc, 64'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

        // Redirect with three entries buffered
        step(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 64'h40, 1'b0);
        check_eq("redir_flush", {63'h0, out_valid}, 64'h0);
        check_eq("redir_addr", mem_addr, 64'h40);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        check_eq("redir_head", out_pc, 64'h40);

        // Halt on zero word at 0x10, then redirect resumes
        zero_addr = 64'h10;
        step(1'b1, 1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("halt_flag", {63'h0, halted}, 64'h1);
        check_eq("halt_addr", mem_addr, 64'h10);
        step(1'b0, 1'b1, 64'h0, 1'b1);
        check_eq("unhalt", {63'h0, halted}, 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("resume_pc", out_pc, 64'h0);
        zero_addr = 64'h3;

        // Full FIFO with simultaneous push/pop, then redirect coincident with pop
        step(1'b1, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("full_head", out_pc, 64'h18);
        step(1'b0, 1'b1, 64'h100, 1'b1);
        check_eq("redir_pop_flush", {63'h0, out_valid}, 64'h0);

        // Reset mid-operation with two entries buffered and pc=0x24
        step(1'b0, 1'b1, 64'h1C, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        check_eq("mid_addr", mem_addr, 64'h24);
        step(1'b1, 1'b0, 64'h0, 1'b0);
        check_eq("mid_rst_valid", {63'h0, out_valid}, 64'h0);
        check_eq("mid_rst_addr", mem_addr, 64'h0);

        // Seven pushes, redirect, reset
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_7", {32'h0, fetch_count}, 64'd7);
`endif
        step(1'b0, 1'b1, 64'h200, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_redir", {32'h0, fetch_count}, 64'd7);
`endif
        step(1'b1, 1'b0, 64'h0, 1'b1);
        check_eq("perf_rst", {32'h0, fetch_count}, 64'd0);

        // PC wrap at 2^64
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 64'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        rv;
            logic [63:0] rp;
            logic        rdy;
            if ($urandom_range(0, 99) < 3) begin
                zero_addr = ($urandom_range(0, 3) == 0) ? 64'h3
                          : {32'h0, 32'($urandom_range(0, 40)) << 2};
            end
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rp  = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'(($urandom_range(0, 3)) << 2))
                                              : {32'h0, 32'($urandom_range(0, 48)) << 2};
            rdy = ($urandom_range(0, 1) == 1);
            step(r, rv, rp, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that drives the program counter into the instruction memory and buffers returned instructions for decode. Owns the PC: sequential +4 advance, redirect from branch resolution (beq), and halt on an all-zero instruction word. Sits between the instruction memory read port and the decoder, with a small FIFO and a valid/ready handshake toward decode.

Parameters:
DATA_WIDTH, 64, width of PC, memory address and instruction words
RESET_PC, 64'h0, PC value loaded on reset
FIFO_DEPTH, 4, fetch buffer entries; power of 2, minimum 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
mem_addr  output  DATA_WIDTH  current PC presented to instruction memory; equals pc register (combinational)
mem_instr  input  DATA_WIDTH  instruction word returned for mem_addr; combinational memory, sampled at the next rising edge
redirect_valid  input  1  branch taken / PC redirect request
redirect_pc  input  DATA_WIDTH  redirect target
out_valid  output  1  FIFO non-empty
out_ready  input  1  decoder accepts head entry
out_pc  output  DATA_WIDTH  PC of head entry; 0 when empty
out_instr  output  DATA_WIDTH  instruction of head entry; 0 when empty
halted  output  1  fetch stopped on zero instruction
fetch_count  output  32  accepted-fetch counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, FIFO emptied (pointers/count 0), halted=0, fetch_count=0. Outputs then: out_valid=0, out_pc=0, out_instr=0, mem_addr=RESET_PC. Reset overrides all other inputs, including mid-stream.
- pop = out_valid & out_ready. push_ok = !halted & (count<FIFO_DEPTH | pop).
- Zero word: mem_instr[31:0]==0.
- Per edge, priority order:
  1. redirect_valid=1: pc<=redirect_pc; FIFO flushed (count=0, head included); halted<=0; no push. A pop coincident with redirect counts as completed from the decoder's view, but the entry is discarded with the flush.
  2. Else if push_ok and zero word: no push, halted<=1, pc unchanged.
  3. Else if push_ok: push {pc, mem_instr}; pc<=pc+4 (modulo 2^DATA_WIDTH, wraps silently).
  4. Else (full without pop, or halted): pc and FIFO hold; mem_addr stays stable.
  - pop is applied in the same edge as push. Full+pop+push keeps count=FIFO_DEPTH, giving throughput 1/cycle.
- Latency: instruction at PC p appears on out_* one cycle after mem_addr=p is sampled. The first out_valid=1 occurs on the 1st edge after reset release.
- FIFO is circular. Pointers wrap at FIFO_DEPTH; count ranges 0..FIFO_DEPTH. No overflow: push is gated. No underflow: pop requires out_valid.
- out_* are driven directly from registered FIFO storage. No combinational path from out_ready to out_valid.
- While halted: the entries already buffered continue draining normally.

Optional Feature:
FETCH_PERF_CNT_EN — when defined, fetch_count increments by 1 on every push (saturating at 32'hFFFF_FFFF), clears only on rst, and is not cleared by redirect. When undefined, fetch_count is tied to 0 and no counter logic is built.

Test Plan:
- Free run: rst 2 cycles, out_ready=1, memory returns 0x33 at every word → out_pc sequence 0x0,0x4,0x8,... one per cycle; out_valid first high 1 edge after reset release; out_instr=0x33.
- Backpressure: out_ready=0 for 10 cycles → count reaches 4, mem_addr holds 0x10; then out_ready=1 → out_pc 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates.
- Redirect: 3 entries buffered, redirect_valid=1 with redirect_pc=0x40 for one cycle → next cycle out_valid=0 and mem_addr=0x40; following cycle out_pc=0x40.
- Halt: memory returns 0 at 0x10 → entries 0x0..0xC delivered, halted=1, mem_addr stays 0x10, no further pushes; redirect to 0x0 → halted=0, fetch resumes at 0x0.
- Simultaneous full push+pop: FIFO full, out_ready=1 → count stays 4 every cycle, consecutive PCs delivered. Redirect coincident with pop → flush wins, count=0.
- Reset mid-operation: rst=1 while 2 entries buffered and pc=0x24 → next cycle out_valid=0 and mem_addr=RESET_PC. With FETCH_PERF_CNT_EN: after 7 pushes fetch_count=7, unchanged by redirect, 0 after rst.
